// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM state encoding and default datapath width.
package alu_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage : alu_pkg

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH-1:0] rem_c_o,
    output logic             q_bit_c_o
);

    // One extra bit keeps the shifted remainder exact when the divisor is >= 2^(WIDTH-1).
    logic [WIDTH:0] shifted_c;
    logic [WIDTH:0] diff_c;

    always_comb begin
        shifted_c = {rem_i, dvd_msb_i};
        diff_c    = shifted_c - {1'b0, dsr_i};
        q_bit_c_o = (shifted_c >= {1'b0, dsr_i});
        rem_c_o   = q_bit_c_o ? WIDTH'(diff_c) : WIDTH'(shifted_c);
    end

endmodule : div_step

// File: rtl/div_iterative.sv
// Multi-cycle signed/unsigned restoring divider on the validIn/validOut handshake.
// Optional DIV_ZERO_TRAP_EN: zero divisor short-circuits to DONE and raises div_zero.
module div_iterative
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             validIn,
    input  logic             sign,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             validOut,
    output logic             busy,
`ifdef DIV_ZERO_TRAP_EN
    output logic             div_zero,
`endif
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             vout_q;
    logic             busy_q;
    logic             trap_c;
    logic [WIDTH-1:0] step_rem_c;
    logic             step_q_c;

`ifdef DIV_ZERO_TRAP_EN
    assign trap_c = (SrcB == '0);
`else
    assign trap_c = 1'b0;
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .dvd_msb_i(dvd_q[WIDTH-1]),
        .dsr_i    (dsr_q),
        .rem_c_o  (step_rem_c),
        .q_bit_c_o(step_q_c)
    );

    // Next-state and datapath; the dividend register doubles as the quotient shift register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (validIn) begin
                    if (trap_c) begin
                        hi_d    = SrcA;
                        lo_d    = '1;
                        state_d = DONE;
                    end else begin
                        neg_a_d = sign & SrcA[WIDTH-1];
                        neg_b_d = sign & SrcB[WIDTH-1];
                        dvd_d   = (sign & SrcA[WIDTH-1]) ? -SrcA : SrcA;
                        dsr_d   = (sign & SrcB[WIDTH-1]) ? -SrcB : SrcB;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = step_rem_c;
                dvd_d = {dvd_q[WIDTH-2:0], step_q_c};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                lo_d    = (neg_a_q ^ neg_b_q) ? -dvd_q : dvd_q;
                hi_d    = neg_a_q ? -rem_q : rem_q;
                state_d = DONE;
            end
            DONE: begin
                if (!validIn) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            vout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            vout_q  <= (state_d == DONE);
            busy_q  <= (state_d == RUN) || (state_d == FIX);
        end
    end

`ifdef DIV_ZERO_TRAP_EN
    logic dz_q;

    // Flag is decided on acceptance in IDLE and held for the whole DONE stay.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dz_q <= 1'b0;
        end else if (state_q == IDLE) begin
            dz_q <= validIn & trap_c;
        end else if (state_d != DONE) begin
            dz_q <= 1'b0;
        end
    end

    assign div_zero = dz_q;
`endif

    assign validOut = vout_q;
    assign busy     = busy_q;
    assign Hi       = hi_q;
    assign Lo       = lo_q;

endmodule : div_iterative

// File: tb/tb_div_iterative.sv
// Scoreboard bench for div_iterative: expected results queued at request, checked at validOut.
module tb_div_iterative;

    localparam int unsigned WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        int               lat;
        bit               dz;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             validIn;
    logic             sign;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             validOut;
    logic             busy;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
`ifdef DIV_ZERO_TRAP_EN
    logic             div_zero;
`endif

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    div_iterative #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .validIn (validIn),
        .sign    (sign),
        .SrcA    (SrcA),
        .SrcB    (SrcB),
        .validOut(validOut),
        .busy    (busy),
`ifdef DIV_ZERO_TRAP_EN
        .div_zero(div_zero),
`endif
        .Hi      (Hi),
        .Lo      (Lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference result; request-edge-to-validOut latency counted in cycles with T0 as cycle 1.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit s);
        exp_t        e;
        logic [63:0] a64;
        logic [63:0] b64;
        logic [63:0] q64;
        logic [63:0] r64;
        logic [WIDTH-1:0] mag;
        e.dz  = 1'b0;
        e.lat = WIDTH + 2;
        if (b == '0) begin
`ifdef DIV_ZERO_TRAP_EN
            e.lo  = '1;
            e.hi  = a;
            e.dz  = 1'b1;
            e.lat = 1;
`else
            mag  = (s && a[WIDTH-1]) ? -a : a;
            e.lo = (s && a[WIDTH-1]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
            e.hi = (s && a[WIDTH-1]) ? -mag : mag;
`endif
        end else if (s) begin
            a64  = {{32{a[WIDTH-1]}}, a};
            b64  = {{32{b[WIDTH-1]}}, b};
            q64  = 64'($signed(a64) / $signed(b64));
            r64  = 64'($signed(a64) % $signed(b64));
            e.lo = 32'(q64);
            e.hi = 32'(r64);
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    // Issue one request, optionally hold validIn past validOut, then release.
    task automatic do_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit s,
                          input int hold, input bit scramble);
        exp_t e;
        int   cyc;
        bit   seen;
        sb.push_back(model(a, b, s));
        SrcA    = a;
        SrcB    = b;
        sign    = s;
        validIn = 1'b1;
        cyc     = 0;
        seen    = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (validOut) begin
                seen = 1'b1;
            end else begin
                if (cyc == 5) check("busy_run", 64'(busy), 64'd1);
                if (scramble && cyc == 3) begin
                    SrcA = $urandom;
                    SrcB = $urandom;
                    sign = ~sign;
                end
            end
        end
        e = sb.pop_front();
        if (!seen) begin
            check("timeout", 64'd0, 64'd1);
            validIn = 1'b0;
            return;
        end
        check("latency", 64'(cyc), 64'(e.lat));
        check("lo", 64'(Lo), 64'(e.lo));
        check("hi", 64'(Hi), 64'(e.hi));
        check("busy_done", 64'(busy), 64'd0);
`ifdef DIV_ZERO_TRAP_EN
        check("div_zero", 64'(div_zero), 64'(e.dz));
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_vout", 64'(validOut), 64'd1);
            check("hold_lo", 64'(Lo), 64'(e.lo));
            check("hold_hi", 64'(Hi), 64'(e.hi));
            check("hold_busy", 64'(busy), 64'd0);
        end
        validIn = 1'b0;
        @(negedge clk);
        check("vout_drop", 64'(validOut), 64'd0);
        check("lo_idle", 64'(Lo), 64'(e.lo));
        check("hi_idle", 64'(Hi), 64'(e.hi));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        validIn = 1'b0;
        sign    = 1'b0;
        SrcA    = '0;
        SrcB    = '0;
        repeat (3) @(negedge clk);
        check("rst_vout", 64'(validOut), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(Hi), 64'd0);
        check("rst_lo", 64'(Lo), 64'd0);
        reset_n = 1'b1;

        do_div(32'd100, 32'd7, 1'b0, 0, 1'b0);
        do_div(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 0, 1'b0);
        do_div(32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 0, 1'b0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b1);

        // Reset in the middle of RUN discards the operation and clears results.
        SrcA    = 32'd100;
        SrcB    = 32'd7;
        sign    = 1'b0;
        validIn = 1'b1;
        repeat (11) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        validIn = 1'b0;
        @(negedge clk);
        check("mid_rst_vout", 64'(validOut), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_hi", 64'(Hi), 64'd0);
        check("mid_rst_lo", 64'(Lo), 64'd0);
        reset_n = 1'b1;
        do_div(32'd12, 32'd5, 1'b0, 0, 1'b0);

        do_div(32'd1234567, 32'd89, 1'b0, 5, 1'b0);
        do_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 0, 1'b0);
        do_div(32'hFFFF_FF00, 32'h0000_0010, 1'b1, 0, 1'b0);
        do_div(32'd9, 32'd0, 1'b0, 0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 30);
            if (rb == '0) rb = 32'd3;
            do_div(ra, rb, 1'($urandom_range(0, 1)), 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_div_iterative
